// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-side FIFO.
// Holds ingress state encodings, default geometry and statistics counter widths.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int RX_BYTE_CNT_W  = 16;
  localparam int DROP_CNT_W     = 8;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_CLR = 1'b1
  } ingress_state_t;

  function automatic logic [RX_BYTE_CNT_W-1:0] sat_inc_rx(input logic [RX_BYTE_CNT_W-1:0] v);
    return (&v) ? v : v + RX_BYTE_CNT_W'(1);
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO.
// Synchronous write port, asynchronous read port (enables first-word fall-through).
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset; the top masks the read while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the consumer: ready/ack ingress, FWFT pop.
// Optional UART_RX_FIFO_STATS_EN adds saturating accepted-byte and dropped-byte counters.
//
//   state      | meaning
//   S_IDLE     | waiting for rx_ready; capture (push or drop) and ack on the edge it is seen
//   S_WAIT_CLR | ack already pulsed; hold until receiver drops rx_ready
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_ready,
  output logic                    rx_ack,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_en,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    full,
  output logic                    overflow,
  input  logic                    clr_overflow
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [RX_BYTE_CNT_W-1:0] rx_byte_cnt,
  output logic [DROP_CNT_W-1:0]    drop_cnt
`endif
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  ingress_state_t          state;
  ingress_state_t          state_nxt;
  logic                    ack_nxt;
  logic                    push_req;
  logic                    pop;
  logic                    wr_ok;
  logic                    drop;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DATA_WIDTH-1:0]   mem_rd_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      rx_ack <= 1'b0;
    end else begin
      state  <= state_nxt;
      rx_ack <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    push_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_ready) begin
          push_req  = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = S_WAIT_CLR;
        end
      end
      S_WAIT_CLR: begin
        if (!rx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_valid = (count != '0);
  assign full     = (count == DEPTH_CNT);
  assign pop      = rd_en & rd_valid;
  // A same-edge pop frees the slot, so a push into a full FIFO still lands.
  assign wr_ok    = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  assign rd_data = rd_valid ? mem_rd_data : '0;

`ifdef UART_RX_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_byte_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (wr_ok) rx_byte_cnt <= sat_inc_rx(rx_byte_cnt);
      if (drop)  drop_cnt    <= sat_inc_drop(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ack;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_en = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clr_overflow = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] rx_byte_cnt;
  logic [7:0]  drop_cnt;
`endif

  logic [7:0] q[$];
  bit         m_ovf;
  int         m_acc;
  int         m_drop;
  int         checks = 0;
  int         errors = 0;

  uart_rx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_ack       (rx_ack),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_en        (rd_en),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .rx_byte_cnt  (rx_byte_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_head();
    if (q.size() > 0) return q[0];
    return 8'h00;
  endfunction

  // One clock: drive inputs, apply the model's queue rules at the edge, settle.
  task automatic tick(input bit rdy, input bit cap, input logic [7:0] d, input bit pop, input bit clr);
    bit dropped;
    rx_ready = rdy; rx_data = d; rd_en = pop; clr_overflow = clr;
    @(posedge clk);
    dropped = 0;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) begin q.push_back(d); m_acc++; end
      else begin dropped = 1; m_ovf = 1; if (m_drop < 255) m_drop++; end
    end
    if (clr && !dropped) m_ovf = 0;
    #1;
    rd_en = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    tick(1, 1, b, 0, 0);
    repeat (hold) tick(1, 0, b, 0, 0);
    tick(0, 0, b, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_ready = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); m_ovf = 0; m_acc = 0; m_drop = 0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL reset_rx_ack got %b want 0", rx_ack); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    reset = 1'b1;
    tick(0, 0, 8'h00, 0, 0);
  endtask

  task automatic test_single();
    tick(1, 1, 8'h41, 0, 0);
    checks++; if (rx_ack !== 1'b1) begin errors++; $display("FAIL single_ack_rise got %b want 1", rx_ack); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL single_rd_data got %h want 41", rd_data); end
    checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL single_count got %0d want %0d", count, q.size()); end
    tick(1, 0, 8'h41, 0, 0);
    checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL single_ack_width got %b want 0", rx_ack); end
    tick(0, 0, 8'h00, 0, 0);
    tick(0, 0, 8'h00, 1, 0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", count); end
  endtask

  task automatic test_late_clear();
    tick(1, 1, 8'h5A, 0, 0);
    checks++; if (rx_ack !== 1'b1) begin errors++; $display("FAIL late_ack got %b want 1", rx_ack); end
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 8'h5A, 0, 0);
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL late_ack_hold%0d got %b want 0", i, rx_ack); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL late_count%0d got %0d want 1", i, count); end
    end
    tick(0, 0, 8'h00, 0, 0);
    tick(1, 1, 8'hC3, 0, 0);
    checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL late_recapture got %0d want %0d", count, q.size()); end
    tick(0, 0, 8'h00, 0, 0);
    while (q.size() > 0) begin
      checks++; if (rd_data !== exp_head()) begin errors++; $display("FAIL late_drain got %h want %h", rd_data, exp_head()); end
      tick(0, 0, 8'h00, 1, 0);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) send(8'(i), 1);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", count); end
    tick(1, 1, 8'hAA, 0, 0);
    checks++; if (rx_ack !== 1'b1) begin errors++; $display("FAIL drop_ack got %b want 1", rx_ack); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL drop_overflow got %b want %b", overflow, m_ovf); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL drop_count got %0d want 16", count); end
    tick(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL fill_order%0d got %h want %h", i, rd_data, 8'(i)); end
      tick(0, 0, 8'h00, 1, 0);
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %b want 0", rd_valid); end
  endtask

  task automatic test_full_simul();
    tick(0, 0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 0);
    tick(1, 1, 8'h55, 1, 0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL simul_full_count got %0d want 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_full_ovf got %b want 0", overflow); end
    tick(0, 0, 8'h00, 0, 0);
    while (q.size() > 0) begin
      checks++; if (rd_data !== exp_head()) begin errors++; $display("FAIL simul_drain got %h want %h", rd_data, exp_head()); end
      if (q.size() == 1) begin
        checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL simul_last got %h want 55", rd_data); end
      end
      tick(0, 0, 8'h00, 1, 0);
    end
    tick(1, 1, 8'h77, 1, 0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL simul_empty_count got %0d want 1", count); end
    checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL simul_empty_data got %h want 77", rd_data); end
    tick(0, 0, 8'h00, 0, 0);
    tick(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_wrap_random();
    logic [7:0] base;
    bit p;
    int hold;
    base = 8'($urandom_range(0, 255));
    for (int n = 0; n < 40; n++) begin
      p = (q.size() >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      tick(1, 1, base + 8'(n), p, 0);
      checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL wrap_count%0d got %0d want %0d", n, count, q.size()); end
      checks++; if (rd_data !== exp_head()) begin errors++; $display("FAIL wrap_data%0d got %h want %h", n, rd_data, exp_head()); end
      hold = $urandom_range(0, 2);
      repeat (hold) tick(1, 0, base + 8'(n), 1'($urandom_range(0, 1)), 0);
      tick(0, 0, 8'h00, 1'($urandom_range(0, 1)), 0);
      checks++; if (rd_data !== exp_head() || rd_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL wrap_head%0d got %h/%b want %h/%b", n, rd_data, rd_valid, exp_head(), q.size() > 0);
      end
    end
    while (q.size() > 0) begin
      checks++; if (rd_data !== exp_head()) begin errors++; $display("FAIL wrap_drain got %h want %h", rd_data, exp_head()); end
      tick(0, 0, 8'h00, 1, 0);
    end
  endtask

  task automatic test_overflow_clr();
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), 0);
    tick(1, 1, 8'hEE, 0, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    tick(0, 0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    send(8'hEF, 0);
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_resticky got %b want %b", overflow, m_ovf); end
    tick(0, 0, 8'h00, 0, 1);
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_clear2 got %b want %b", overflow, m_ovf); end
`ifdef UART_RX_FIFO_STATS_EN
    checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL stats_drop got %0d want %0d", drop_cnt, m_drop); end
    checks++; if (rx_byte_cnt !== 16'(m_acc)) begin errors++; $display("FAIL stats_acc got %0d want %0d", rx_byte_cnt, m_acc); end
`endif
    send(8'hF0, 0);
    for (int i = 0; i < 11; i++) tick(0, 0, 8'h00, 1, 0);
    checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL ovf_count5 got %0d want %0d", count, q.size()); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; rx_ready = 1'b1; rx_data = 8'hE7;
    @(posedge clk);
    #1;
    q.delete(); m_ovf = 0; m_acc = 0; m_drop = 0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", overflow); end
    checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack got %b want 0", rx_ack); end
    reset = 1'b1;
    tick(1, 1, 8'hE7, 0, 0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL rmid_recapture got %0d want 1", count); end
    checks++; if (rd_data !== 8'hE7) begin errors++; $display("FAIL rmid_data got %h want e7", rd_data); end
`ifdef UART_RX_FIFO_STATS_EN
    checks++; if (rx_byte_cnt !== 16'd1) begin errors++; $display("FAIL rmid_stats_acc got %0d want 1", rx_byte_cnt); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_stats_drop got %0d want 0", drop_cnt); end
`endif
    tick(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_late_clear();
    test_fill();
    test_full_simul();
    test_wrap_random();
    test_overflow_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Consumes the receiver's byte and level-held `ready` flag, and returns a one-cycle acknowledge to the receiver's `reset_ready` input.
- Stores bytes in a circular FIFO and presents them to the consumer (command parser / core) with a first-word-fall-through pop interface.
- Decouples bursty serial arrival from a consumer that may stall.

Parameters:
- DATA_WIDTH, 8, byte width; matches receiver data output.
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries).

Ports:
- clk  input  1  system clock, same clock as the UART receiver.
- reset  input  1  synchronous, active-low reset.
- rx_data  input  DATA_WIDTH  byte from receiver; valid while rx_ready=1.
- rx_ready  input  1  receiver byte-available flag; level, held until acknowledged.
- rx_ack  output  1  one-cycle pulse to receiver reset_ready; clears rx_ready.
- rd_data  output  DATA_WIDTH  head-of-FIFO byte; valid when rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- rd_en  input  1  pop head; honoured only when rd_valid=1.
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=S_IDLE; wr_ptr=rd_ptr=0; count=0.
  - rx_ack=0, overflow=0, rd_valid=0, full=0.
  - rd_data=0 (memory contents don't-care, output forced 0 while empty).
- Ingress FSM, 2 states (constants S_IDLE, S_WAIT_CLR):
  - S_IDLE:
    - If rx_ready=1 at an edge, on that edge: push rx_data (or drop if full), rx_ack<=1, go to S_WAIT_CLR.
    - Otherwise stay in S_IDLE.
  - S_WAIT_CLR:
    - rx_ack<=0 on the first edge, so rx_ack is exactly one cycle wide.
    - Stay until rx_ready sampled 0, then go to S_IDLE.
    - Guarantees one push per received byte even if the receiver clears late.
- Latency:
  - rx_ready rising -> byte visible on rd_data/rd_valid after the first sampling edge (1 cycle).
  - Back-to-back minimum ingress spacing is 3 cycles (capture, wait-clear, idle); this is far below one UART bit time.
- Push when full: byte discarded, overflow<=1, rx_ack still pulsed (receiver must not stall), pointers unchanged.
- Pop: when rd_en=1 and rd_valid=1, rd_ptr increments on the edge; rd_en while empty is ignored with no pointer change.
- Simultaneous push and pop:
  - Not full: both occur, count unchanged.
  - Full: pop frees a slot in the same edge, so push succeeds, count stays DEPTH, no overflow.
  - Empty: pop ignored, push succeeds, count=1.
- Pointers: DEPTH_LOG2 bits each, wrap modulo DEPTH; count is tracked separately and is never derived from a pointer difference.
- rd_data is the memory read at rd_ptr, combinational from registered storage (first-word fall-through).
- overflow:
  - Set on a dropped push; cleared by clr_overflow=1.
  - If a drop and clr_overflow coincide, set wins.
- Reset mid-operation: everything returns to reset values; a pending rx_ready=1 is recaptured after reset deasserts, because the receiver still holds it.

Optional Feature:
- Macro: UART_RX_FIFO_STATS_EN.
- Defined:
  - Adds outputs `rx_byte_cnt` (16 bits, +1 per accepted push) and `drop_cnt` (8 bits, +1 per dropped byte).
  - Both counters saturate at all-ones and clear on reset.
  - `drop_cnt` is unaffected by clr_overflow.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `uart_pkg`:
  - ingress state encodings S_IDLE/S_WAIT_CLR;
  - DATA_WIDTH default 8;
  - default DEPTH_LOG2;
  - counter widths used by STATS.
- One sub-module, `uart_fifo_mem`:
  - holds the DEPTH x DATA_WIDTH register array;
  - synchronous write port, asynchronous read port;
  - write-enable and address inputs.
- The top holds the FSM, pointers, count, flags and stats.

Test Plan:
- Single byte: rx_data=0x41, rx_ready held until rx_ack -> rx_ack high exactly 1 cycle; next cycle rd_valid=1, rd_data=0x41, count=1; pulse rd_en -> rd_valid=0, count=0.
- Late clear: rx_ready held 5 cycles after rx_ack -> exactly one push, count=1, FSM returns to S_IDLE only after rx_ready=0.
- Fill: push 0x00..0x0F without popping -> full=1, count=16; push 0xAA -> rx_ack pulses, overflow=1, count=16; pop 16 times -> 0x00..0x0F in order, then rd_valid=0.
- Full with simultaneous push 0x55 and pop -> count stays 16, overflow stays 0, 0x55 emerges last; with an empty FIFO and rd_en=1 plus push 0x77 -> count=1, rd_data=0x77.
- Wrap: 40 bytes of an incrementing pattern with interleaved pops keeping count ≤ 3 -> output order is correct across pointer wrap; clr_overflow clears the flag, and a drop in the same cycle keeps it set.
- Reset at count=5 with rx_ready=1 -> count=0, rd_valid=0, overflow=0; after release, the held byte is captured (count=1). With STATS_EN defined, rx_byte_cnt=1 and drop_cnt=0.
